// File: rtl/binary_to_bcd_converter_pkg.sv
// rtl/binary_to_bcd_converter_pkg.sv - shared seven-segment constants and FSM encoding
//
// Purpose: state encoding for the binary-to-BCD converter FSM, the BCD digit
// width, and a constant helper giving the largest value representable in a
// given number of decimal digits.
// Ports: none (package).
package binary_to_bcd_converter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // 10^digits - 1, evaluated at elaboration time for the overflow limit.
  function automatic longint unsigned max_decimal(input int digits);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble nibble correction
//
// Purpose: pre-shift correction of one BCD digit; a nibble of 5 or more gets 3
// added so that the following left shift carries correctly into the next digit.
// Ports:
//   nibble   in  DIGIT_W  current scratch digit
//   adjusted out DIGIT_W  nibble + 3 when nibble >= 5, else nibble
module bcd_digit_adjust
  import binary_to_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (nibble >= DIGIT_W'(5)) ? nibble + DIGIT_W'(3) : nibble;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// rtl/binary_to_bcd_converter.sv - sequential double-dabble binary to packed BCD converter
//
// Purpose: converts an unsigned binary value into NUM_DIGITS packed BCD digits
// using one double-dabble iteration per clock, saturating to all nines when the
// value does not fit.
// Ports:
//   clock    in   1               rising-edge clock
//   resetN   in   1               asynchronous active-low reset
//   start    in   1               conversion request (honoured in IDLE/FINISH)
//   binary   in   BIN_WIDTH       value sampled on an accepted start
//   busy     out  1               high while iterating (SHIFT)
//   done     out  1               one-cycle completion pulse (FINISH)
//   bcd      out  4*NUM_DIGITS    registered result, digit 0 in bits [3:0]
//   overflow out  1               registered: last accepted input did not fit
module binary_to_bcd_converter
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          start,
  input  logic [BIN_WIDTH-1:0]          binary,
  output logic                          busy,
  output logic                          done,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int ALL_W = BCD_W + BIN_WIDTH;

  localparam longint unsigned MAX_DEC  = max_decimal(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BCD_W-1:0] SAT_BCD  = {NUM_DIGITS{4'h9}};

  state_t                 state;
  state_t                 state_next;
  logic [BIN_WIDTH-1:0]   shift_bin;
  logic [BCD_W-1:0]       scratch;
  logic [CNT_W-1:0]       count;
  logic                   ovf_pending;

  logic [BCD_W-1:0]       adjusted;
  logic [ALL_W-1:0]       combined;
  logic [BCD_W-1:0]       scratch_shifted;
  logic [BIN_WIDTH-1:0]   bin_shifted;
  logic                   accept;
  logic                   last_iter;
  logic                   exceeds;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .nibble   (scratch[d*DIGIT_W +: DIGIT_W]),
      .adjusted (adjusted[d*DIGIT_W +: DIGIT_W])
    );
  end

  // The top bit shifted out of the scratch is dropped; such inputs are
  // exactly the ones caught by the overflow compare and saturated anyway.
  assign combined        = {adjusted, shift_bin} << 1;
  assign scratch_shifted = combined[ALL_W-1 -: BCD_W];
  assign bin_shifted     = combined[BIN_WIDTH-1:0];

  assign accept    = start && ((state == IDLE) || (state == FINISH));
  assign last_iter = (state == SHIFT) && (count == CNT_ONE);
  assign exceeds   = 64'(binary) > MAX_DEC;

  assign busy = (state == SHIFT);
  assign done = (state == FINISH);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == CNT_ONE) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        // A start seen here restarts immediately for back-to-back use.
        state_next = start ? SHIFT : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      shift_bin   <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      bcd         <= '0;
      overflow    <= 1'b0;
    end else if (accept) begin
      shift_bin   <= binary;
      scratch     <= '0;
      count       <= CNT_LOAD;
      ovf_pending <= exceeds;
    end else if (state == SHIFT) begin
      shift_bin <= bin_shifted;
      scratch   <= scratch_shifted;
      count     <= count - CNT_ONE;
      if (last_iter) begin
        bcd      <= ovf_pending ? SAT_BCD : scratch_shifted;
        overflow <= ovf_pending;
      end
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// tb/tb_binary_to_bcd_converter.sv - self-checking bench for binary_to_bcd_converter
module tb_binary_to_bcd_converter;

  localparam int ND = 4;
  localparam int BW = 14;

  logic        clock;
  logic        resetN;
  logic        start;
  logic [13:0] binary;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int tests;
  int fails;
  int cyc;

  binary_to_bcd_converter #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .start    (start),
    .binary   (binary),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference by plain arithmetic, saturating above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'h9999;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: a conversion lasts BW edges; the result appears with
  // a done pulse, and start is ignored while a conversion is outstanding.
  logic        m_busy;
  logic        m_done;
  int          m_left;
  int          m_val;
  logic [15:0] exp_bcd;
  logic        exp_ovf;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_left  = 0;
      exp_bcd = '0;
      exp_ovf = 1'b0;
    end else begin
      cyc++;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          exp_bcd = ref_bcd(m_val);
          exp_ovf = (m_val > 9999);
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          m_busy = 1'b1;
          m_left = BW;
          m_val  = int'(binary);
        end
      end
    end
  end

  int done_q[$];

  always @(negedge clock) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("bcd", 64'(bcd), 64'(exp_bcd));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    if (done === 1'b1) done_q.push_back(cyc);
  end

  // Called #1 after a rising edge; accepting edge is the next one.
  // Returns edges from accept to done and number of busy cycles before done.
  task automatic run_conv(input int v, output int edges, output int bcnt);
    start  = 1'b1;
    binary = 14'(v);
    @(posedge clock); #1;
    start = 1'b0;
    bcnt  = busy ? 1 : 0;
    edges = 0;
    while (edges < 40) begin
      @(posedge clock); #1;
      edges++;
      if (done) break;
      if (busy) bcnt++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic idle();
    @(posedge clock); #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    int e;
    int b;
    int q0;
    int v;
    tests  = 0;
    fails  = 0;
    cyc    = 0;
    start  = 1'b0;
    binary = '0;
    resetN = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Release reset and request in the same cycle: first edge accepts.
    resetN = 1'b1;
    run_conv(1234, e, b);
    chk("1234_latency", 64'(e), 64'd14);
    chk("1234_busy_cycles", 64'(b), 64'd14);
    chk("1234_bcd", 64'(bcd), 64'h1234);
    chk("1234_ovf", 64'(overflow), 64'd0);

    idle(); run_conv(0, e, b);
    chk("0_bcd", 64'(bcd), 64'h0000);
    chk("0_ovf", 64'(overflow), 64'd0);
    idle(); run_conv(9999, e, b);
    chk("9999_bcd", 64'(bcd), 64'h9999);
    chk("9999_ovf", 64'(overflow), 64'd0);
    idle(); run_conv(16383, e, b);
    chk("16383_bcd", 64'(bcd), 64'h9999);
    chk("16383_ovf", 64'(overflow), 64'd1);
    idle(); run_conv(10000, e, b);
    chk("10000_ovf", 64'(overflow), 64'd1);

    // Start with 42 during the 5th SHIFT cycle of converting 7.
    idle();
    q0 = done_q.size();
    start = 1'b1; binary = 14'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1; binary = 14'd42;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("ignore_done_seen");
    chk("ignore_bcd", 64'(bcd), 64'h0007);
    repeat (30) @(posedge clock);
    #1;
    chk("ignore_pulses", 64'(done_q.size() - q0), 64'd1);

    // Back-to-back: start held through FINISH of 500, then 8.
    idle();
    q0 = done_q.size();
    run_conv(500, e, b);
    chk("b2b_first_bcd", 64'(bcd), 64'h0500);
    start = 1'b1; binary = 14'd8;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("b2b_second_done");
    chk("b2b_second_bcd", 64'(bcd), 64'h0008);
    #5;
    if (done_q.size() >= q0 + 2)
      chk("b2b_gap", 64'(done_q[q0+1] - done_q[q0]), 64'd15);
    else
      chk("b2b_pulses", 64'(done_q.size() - q0), 64'd2);

    // Reset mid-conversion of 3000.
    idle(); idle();
    start = 1'b1; binary = 14'd3000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    resetN = 1'b0;
    #1;
    chk("midrst_bcd", 64'(bcd), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    q0 = done_q.size();
    @(posedge clock); #1;
    resetN = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    chk("midrst_no_done", 64'(done_q.size() - q0), 64'd0);

    // Sweep.
    for (int i = 0; i < 40; i++) begin
      v = (i == 0) ? 9998 : (i == 1) ? 1 : int'($urandom_range(0, 16383));
      idle(); run_conv(v, e, b);
      chk("sweep_bcd", 64'(bcd), 64'(ref_bcd(v)));
      chk("sweep_ovf", 64'(overflow), 64'(v > 9999));
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_converter.md
BINARY_TO_BCD_CONVERTER -- requirements
Module: binary_to_bcd_converter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD output digits.
REQ-002 SHALL have parameter BIN_WIDTH, default 14: width of the binary input.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to convert the value on binary.
REQ-006 SHALL have port binary  input  BIN_WIDTH  unsigned value to convert, sampled only on an accepted start.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 SHALL have port bcd  output  4*NUM_DIGITS  registered packed BCD result, digit 0 in bits [3:0]; this is the data input of the seven-segment display stage.
REQ-010 SHALL have port overflow  output  1  registered flag: last accepted input exceeded 10^NUM_DIGITS-1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and FINISH.
REQ-012 SHALL accept start only in IDLE or FINISH; an accepting edge captures binary into a shift register, clears the BCD scratch register, loads the iteration counter with BIN_WIDTH and enters SHIFT.
REQ-013 SHALL ignore start while in SHIFT, with no effect on the conversion, bcd or overflow.
REQ-014 SHALL perform one double-dabble iteration per SHIFT cycle: add 3 to every scratch nibble >= 5, then shift the combined {scratch, binary} register left by one bit.
REQ-015 SHALL perform exactly BIN_WIDTH iterations; the edge that performs the last iteration loads bcd and overflow and enters FINISH.
REQ-016 SHALL drive done=1 for exactly the one cycle spent in FINISH; done is first high BIN_WIDTH edges after the accepting edge.
REQ-017 SHALL drive busy=1 exactly while in SHIFT, and busy=0 in IDLE and FINISH.
REQ-018 SHALL leave FINISH for IDLE on the next edge unless start is high, in which case that edge is an accepting edge (back-to-back conversion).
REQ-019 SHALL compare the captured input against 10^NUM_DIGITS-1; on exceed, bcd SHALL saturate to all nibbles 4'h9 and overflow SHALL be 1, otherwise overflow SHALL be 0.
REQ-020 SHALL hold bcd and overflow unchanged between completions.
REQ-021 SHALL size the iteration counter as clog2(BIN_WIDTH+1) bits and use the scratch register width 4*NUM_DIGITS; carries out of the top nibble SHALL be discarded (covered by the saturation in REQ-019).

Reset
REQ-022 SHALL, when resetN is low, asynchronously force state=IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0 and the scratch register to 0.
REQ-023 SHALL abandon any conversion in progress on reset, with no done pulse after reset release until a new start is accepted.
REQ-024 SHALL accept start on the first rising edge after resetN deasserts.

Structure
REQ-025 SHALL take the FSM state encoding and the BCD digit width constant (4) from the shared seven-segment package.
REQ-026 SHALL instantiate one sub-module per digit, bcd_digit_adjust: a 4-bit nibble input giving nibble+3 when >= 5, otherwise the nibble unchanged.
REQ-027 SHALL be purely synchronous apart from the reset, with no latches and no combinational path from start to done.

Verification
REQ-028 SHALL verify: binary=1234, start pulse -> done exactly 14 edges later, bcd=16'h1234, overflow=0, busy high for the 14 cycles before done.
REQ-029 SHALL verify the boundaries: binary=0 -> bcd=16'h0000; binary=9999 -> bcd=16'h9999, overflow=0; binary=16383 -> bcd=16'h9999, overflow=1.
REQ-030 SHALL verify: start with binary=42 at the 5th SHIFT cycle of a conversion of 7 -> ignored, result bcd=16'h0007, and only one done pulse.
REQ-031 SHALL verify back-to-back operation: start held high through the FINISH cycle of 500 with binary=8 -> bcd=16'h0500 then bcd=16'h0008, with done pulses 15 edges apart.
REQ-032 SHALL verify: resetN pulsed low mid-conversion of 3000 -> bcd=0, busy=0, overflow=0 immediately, and no done pulse follows.
REQ-033 SHALL verify: a randomised sweep of 0..16383 is checked against a reference model for bcd and overflow.
